// File: rtl/stream_fifo.sv
// First-word-fall-through valid/ready FIFO with registered occupancy count.
// Define STREAM_FIFO_SUM_CHECK_EN to elaborate the running checksum of stored words on 'sum'.
module stream_fifo #(
    parameter int DATA_W = 9,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic [15:0]              sum
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] FullCount = (ADDR_W + 1)'(DEPTH);

    // Pointer wrap relies on natural overflow, so only power-of-two depths are legal.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depthCheck
        $error("stream_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wrPtr_q, wrPtr_d;
    logic [ADDR_W-1:0] rdPtr_q, rdPtr_d;
    logic [ADDR_W:0]   count_q, count_d;

    logic push;
    logic pop;
    logic clearState;

    assign in_ready   = (count_q != FullCount);
    assign out_valid  = (count_q != '0);
    assign out_data   = mem[rdPtr_q];
    assign count      = count_q;

    assign clearState = rst | flush;
    assign push       = in_valid & in_ready & ~clearState;
    assign pop        = out_valid & out_ready & ~clearState;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (clearState) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (push) begin
                wrPtr_d = wrPtr_q + ADDR_W'(1);
            end
            if (pop) begin
                rdPtr_d = rdPtr_q + ADDR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + (ADDR_W + 1)'(1);
            end else if (pop && !push) begin
                count_d = count_q - (ADDR_W + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage is deliberately left uncleared by rst/flush; stale words sit behind the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr_q] <= in_data;
        end
    end

`ifdef STREAM_FIFO_SUM_CHECK_EN
    logic [15:0] sum_q, sum_d;

    function automatic logic [15:0] sumUpdate(
        input logic [15:0]       cur,
        input logic              doPush,
        input logic              doPop,
        input logic [DATA_W-1:0] pushWord,
        input logic [DATA_W-1:0] popWord
    );
        logic [15:0] acc;
        acc = cur;
        if (doPush) begin
            acc = acc + 16'(pushWord);
        end
        if (doPop) begin
            acc = acc - 16'(popWord);
        end
        return acc;
    endfunction

    always_comb begin
        sum_d = sumUpdate(sum_q, push, pop, in_data, out_data);
        if (clearState) begin
            sum_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum = sum_q;
`else
    assign sum = 16'd0;
`endif

endmodule

// File: tb/tb_stream_fifo.sv
// Self-checking bench for stream_fifo: directed scenarios plus random traffic
// compared against a queue-based model of the FIFO contents.
module tb_stream_fifo;

    localparam int DATA_W = 9;
    localparam int DEPTH  = 8;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [DATA_W-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [DATA_W-1:0] out_data;
    logic [3:0]       count;
    logic [15:0]      sum;

    int total;
    int bad;

    logic [DATA_W-1:0] modelQ [$];

    stream_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .sum       (sum)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Checksum expected from the model: sum of stored words modulo 2^16, or zero when disabled.
    function automatic logic [15:0] modelSum();
        logic [15:0] acc;
        acc = 16'd0;
`ifdef STREAM_FIFO_SUM_CHECK_EN
        foreach (modelQ[i]) acc = acc + 16'(modelQ[i]);
`endif
        return acc;
    endfunction

    function automatic logic [15:0] expectSum(input int value);
        logic [15:0] r;
        r = 16'd0;
`ifdef STREAM_FIFO_SUM_CHECK_EN
        r = 16'(value);
`endif
        return r;
    endfunction

    // One clock cycle: drive at negedge, update the model at posedge, return at the next negedge.
    task automatic tick(input logic iv, input logic [DATA_W-1:0] d, input logic ordy,
                        input logic rs, input logic fl);
        bit doPush;
        bit doPop;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        rst       = rs;
        flush     = fl;
        doPush = iv && (modelQ.size() < DEPTH);
        doPop  = ordy && (modelQ.size() > 0);
        @(posedge clk);
        if (rs || fl) begin
            modelQ.delete();
        end else begin
            if (doPop) void'(modelQ.pop_front());
            if (doPush) modelQ.push_back(d);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        tick(1'b1, 9'h005, 1'b0, 1'b1, 1'b0);
        tick(1'b1, 9'h006, 1'b0, 1'b1, 1'b0);
        total++; if (count !== 4'd0) begin bad++; $display("[TB] FAIL reset_count: got %0d want 0", count); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (sum !== 16'd0) begin bad++; $display("[TB] FAIL reset_sum: got %0d want 0", sum); end
        tick(1'b0, 9'h000, 1'b0, 1'b0, 1'b0);
        total++; if (count !== 4'd0) begin bad++; $display("[TB] FAIL reset_no_accept: got %0d want 0", count); end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= DEPTH; i++) begin
            tick(1'b1, DATA_W'(i), 1'b0, 1'b0, 1'b0);
            total++; if (count !== 4'(i)) begin bad++; $display("[TB] FAIL fill_count_%0d: got %0d want %0d", i, count, i); end
        end
        total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL fill_in_ready: got %b want 0", in_ready); end
        total++; if (sum !== expectSum(36)) begin bad++; $display("[TB] FAIL fill_sum: got %0d want %0d", sum, expectSum(36)); end
        tick(1'b1, 9'h1FF, 1'b0, 1'b0, 1'b0);
        total++; if (count !== 4'd8) begin bad++; $display("[TB] FAIL fill_refused_count: got %0d want 8", count); end
        total++; if (out_data !== 9'h001) begin bad++; $display("[TB] FAIL fill_head: got %0h want 001", out_data); end
    endtask

    task automatic test_drain();
        int remaining;
        remaining = 36;
        for (int i = 1; i <= DEPTH; i++) begin
            total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL drain_valid_%0d: got %b want 1", i, out_valid); end
            total++; if (out_data !== DATA_W'(i)) begin bad++; $display("[TB] FAIL drain_data_%0d: got %0h want %0h", i, out_data, i); end
            total++; if (sum !== expectSum(remaining)) begin bad++; $display("[TB] FAIL drain_sum_%0d: got %0d want %0d", i, sum, expectSum(remaining)); end
            remaining -= i;
            tick(1'b0, 9'h000, 1'b1, 1'b0, 1'b0);
        end
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL drain_empty_valid: got %b want 0", out_valid); end
        total++; if (count !== 4'd0) begin bad++; $display("[TB] FAIL drain_empty_count: got %0d want 0", count); end
        total++; if (sum !== 16'd0) begin bad++; $display("[TB] FAIL drain_empty_sum: got %0d want 0", sum); end
    endtask

    task automatic test_streaming();
        tick(1'b1, 9'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < 20; i++) begin
            total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL stream_valid_%0d: got %b want 1", i, out_valid); end
            total++; if (out_data !== DATA_W'(i - 1)) begin bad++; $display("[TB] FAIL stream_data_%0d: got %0h want %0h", i, out_data, i - 1); end
            total++; if (count !== 4'd1) begin bad++; $display("[TB] FAIL stream_count_%0d: got %0d want 1", i, count); end
            tick(1'b1, DATA_W'(i), 1'b1, 1'b0, 1'b0);
        end
        total++; if (out_data !== 9'd19) begin bad++; $display("[TB] FAIL stream_last: got %0h want 13", out_data); end
        tick(1'b0, 9'd0, 1'b1, 1'b0, 1'b0);
        total++; if (count !== 4'd0) begin bad++; $display("[TB] FAIL stream_end_count: got %0d want 0", count); end
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < DEPTH; i++) begin
            tick(1'b1, DATA_W'($urandom), 1'b0, 1'b0, 1'b0);
        end
        tick(1'b1, 9'h0AA, 1'b1, 1'b0, 1'b0);
        total++; if (count !== 4'd7) begin bad++; $display("[TB] FAIL fullpop_count: got %0d want 7", count); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL fullpop_in_ready: got %b want 1", in_ready); end
        tick(1'b1, 9'h0AA, 1'b0, 1'b0, 1'b0);
        total++; if (count !== 4'd8) begin bad++; $display("[TB] FAIL fullpop_refill: got %0d want 8", count); end
        total++; if (sum !== modelSum()) begin bad++; $display("[TB] FAIL fullpop_sum: got %0d want %0d", sum, modelSum()); end
        for (int i = 0; i < DEPTH; i++) begin
            total++; if (out_data !== modelQ[0]) begin bad++; $display("[TB] FAIL fullpop_drain_%0d: got %0h want %0h", i, out_data, modelQ[0]); end
            tick(1'b0, 9'h000, 1'b1, 1'b0, 1'b0);
        end
        total++; if (count !== 4'd0) begin bad++; $display("[TB] FAIL fullpop_empty: got %0d want 0", count); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, DATA_W'(9'h040 + i), 1'b0, 1'b0, 1'b0);
        end
        total++; if (count !== 4'd5) begin bad++; $display("[TB] FAIL flush_pre_count: got %0d want 5", count); end
        tick(1'b1, 9'h055, 1'b1, 1'b0, 1'b1);
        total++; if (count !== 4'd0) begin bad++; $display("[TB] FAIL flush_count: got %0d want 0", count); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_valid: got %b want 0", out_valid); end
        total++; if (sum !== 16'd0) begin bad++; $display("[TB] FAIL flush_sum: got %0d want 0", sum); end
        tick(1'b1, 9'h123, 1'b0, 1'b0, 1'b0);
        total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL flush_after_valid: got %b want 1", out_valid); end
        total++; if (out_data !== 9'h123) begin bad++; $display("[TB] FAIL flush_after_data: got %0h want 123", out_data); end
        total++; if (sum !== expectSum(9'h123)) begin bad++; $display("[TB] FAIL flush_after_sum: got %0d want %0d", sum, expectSum(9'h123)); end
        tick(1'b0, 9'h000, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic iv;
        logic ordy;
        logic fl;
        for (int n = 0; n < 400; n++) begin
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            fl   = ($urandom_range(0, 49) == 0);
            tick(iv, DATA_W'($urandom), ordy, 1'b0, fl);
            total++; if (count !== 4'(modelQ.size())) begin bad++; $display("[TB] FAIL rand_count_%0d: got %0d want %0d", n, count, modelQ.size()); end
            total++; if (in_ready !== (modelQ.size() < DEPTH)) begin bad++; $display("[TB] FAIL rand_in_ready_%0d: got %b", n, in_ready); end
            total++; if (out_valid !== (modelQ.size() > 0)) begin bad++; $display("[TB] FAIL rand_out_valid_%0d: got %b", n, out_valid); end
            total++; if (sum !== modelSum()) begin bad++; $display("[TB] FAIL rand_sum_%0d: got %0d want %0d", n, sum, modelSum()); end
            if (modelQ.size() > 0) begin
                total++; if (out_data !== modelQ[0]) begin bad++; $display("[TB] FAIL rand_data_%0d: got %0h want %0h", n, out_data, modelQ[0]); end
            end
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        test_reset();
        test_fill();
        test_drain();
        test_streaming();
        test_full_pop();
        test_flush();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
